n_bit_register: RTL and testbench

Parameterised N-bit storage register with a write-enable, the basic state element of the datapath. It is used for accumulators, general-purpose registers and pipeline latches throughout the CPU. It captures `data_in` on a rising clock edge when `write_enable` is high and otherwise holds its contents. The stored word is always driven on `data_out`.

---
 rtl/n_bit_register_pkg.sv | 12 +
 rtl/register_bit_cell.sv | 20 ++
 rtl/n_bit_register.sv | 57 +++++
 tb/tb_n_bit_register.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/n_bit_register_pkg.sv
// Shared width limits and parity helper for the n_bit_register slice.
package n_bit_register_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned MAX_WIDTH     = 64;

    // Even parity over a word; narrower words are zero-extended by the caller.
    function automatic logic even_parity(input logic [MAX_WIDTH-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/register_bit_cell.sv
// Single storage bit with synchronous active-high reset and load enable.
module register_bit_cell #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_BIT;
        end else if (enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/n_bit_register.sv
// N-bit write-enabled register built from register_bit_cell instances.
// Optional registered even-parity output: define N_BIT_REGISTER_PARITY_EN.
module n_bit_register
    import n_bit_register_pkg::*;
#(
    parameter int unsigned    N           = DEFAULT_WIDTH,
    parameter logic [N-1:0]   RESET_VALUE = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] data_in,
    input  logic         write_enable,
    output logic [N-1:0] data_out
`ifdef N_BIT_REGISTER_PARITY_EN
    ,
    output logic         parity_out
`endif
);

    if (N == 0 || N > MAX_WIDTH) begin : g_bad_width
        $error("n_bit_register: N=%0d outside legal range 1..%0d", N, MAX_WIDTH);
    end

    for (genvar i = 0; i < int'(N); i++) begin : g_bit
        register_bit_cell #(
            .RESET_BIT (RESET_VALUE[i])
        ) u_cell (
            .clk    (clk),
            .reset  (reset),
            .enable (write_enable),
            .d      (data_in[i]),
            .q      (data_out[i])
        );
    end

`ifdef N_BIT_REGISTER_PARITY_EN
    // Parity is computed from the incoming word so it lands on the same edge as the data.
    localparam logic RESET_PARITY = even_parity(MAX_WIDTH'(RESET_VALUE));

    logic parity_next_c;

    always_comb begin
        parity_next_c = even_parity(MAX_WIDTH'(data_in));
    end

    register_bit_cell #(
        .RESET_BIT (RESET_PARITY)
    ) u_parity_cell (
        .clk    (clk),
        .reset  (reset),
        .enable (write_enable),
        .d      (parity_next_c),
        .q      (parity_out)
    );
`endif

endmodule

// File: tb/tb_n_bit_register.sv
// Directed self-checking bench for n_bit_register at widths 8, 1 and 32.
// Parity checks are included when N_BIT_REGISTER_PARITY_EN is defined.
module tb_n_bit_register;

    logic        clk = 1'b0;
    logic        reset;
    logic        write_enable;
    logic [7:0]  d8;
    logic [0:0]  d1;
    logic [31:0] d32;
    logic [7:0]  q8;
    logic [0:0]  q1;
    logic [31:0] q32;
`ifdef N_BIT_REGISTER_PARITY_EN
    logic        p8, p1, p32;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    n_bit_register #(.N(8)) u_dut8 (
        .clk          (clk),
        .reset        (reset),
        .data_in      (d8),
        .write_enable (write_enable),
        .data_out     (q8)
`ifdef N_BIT_REGISTER_PARITY_EN
        ,
        .parity_out   (p8)
`endif
    );

    n_bit_register #(.N(1)) u_dut1 (
        .clk          (clk),
        .reset        (reset),
        .data_in      (d1),
        .write_enable (write_enable),
        .data_out     (q1)
`ifdef N_BIT_REGISTER_PARITY_EN
        ,
        .parity_out   (p1)
`endif
    );

    n_bit_register #(.N(32)) u_dut32 (
        .clk          (clk),
        .reset        (reset),
        .data_in      (d32),
        .write_enable (write_enable),
        .data_out     (q32)
`ifdef N_BIT_REGISTER_PARITY_EN
        ,
        .parity_out   (p32)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] b2b_vals   [3] = '{8'h01, 8'h80, 8'h3C};
    logic       b2b_parity [3] = '{1'b1, 1'b1, 1'b0};

    initial begin
        reset        = 1'b1;
        write_enable = 1'b1;
        d8           = 8'hA5;
        d1           = 1'b1;
        d32          = 32'hFFFF_FFFF;

        // Reset held two edges with a write pending: writes are blocked.
        step();
        chk("reset_e1_q8", 64'(q8), 64'h00);
        chk("reset_e1_q1", 64'(q1), 64'h0);
        chk("reset_e1_q32", 64'(q32), 64'h0);
        step();
        chk("reset_e2_q8", 64'(q8), 64'h00);
        chk("reset_e2_q1", 64'(q1), 64'h0);
        chk("reset_e2_q32", 64'(q32), 64'h0);
`ifdef N_BIT_REGISTER_PARITY_EN
        chk("reset_p8", 64'(p8), 64'h0);
        chk("reset_p32", 64'(p32), 64'h0);
`endif

        // Single write: visible after the edge, not before.
        reset = 1'b0;
        d8    = 8'hFF;
        d1    = 1'b1;
        d32   = 32'hDEAD_BEEF;
        #1;
        chk("write_before_edge_q8", 64'(q8), 64'h00);
        chk("write_before_edge_q32", 64'(q32), 64'h0);
        step();
        chk("write_q8", 64'(q8), 64'hFF);
        chk("write_q1", 64'(q1), 64'h1);
        chk("write_q32", 64'(q32), 64'hDEAD_BEEF);
`ifdef N_BIT_REGISTER_PARITY_EN
        chk("write_p8", 64'(p8), 64'h0);
        chk("write_p1", 64'(p1), 64'h1);
        chk("write_p32", 64'(p32), 64'h0);
`endif

        // Hold for three edges while data_in changes.
        write_enable = 1'b0;
        d8           = 8'h0F;
        d1           = 1'b0;
        d32          = 32'h0000_0001;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("hold%0d_q8", k), 64'(q8), 64'hFF);
            chk($sformatf("hold%0d_q1", k), 64'(q1), 64'h1);
            chk($sformatf("hold%0d_q32", k), 64'(q32), 64'hDEAD_BEEF);
`ifdef N_BIT_REGISTER_PARITY_EN
            chk($sformatf("hold%0d_p8", k), 64'(p8), 64'h0);
`endif
        end

        // Back-to-back writes on consecutive edges.
        write_enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d8  = b2b_vals[k];
            d1  = b2b_vals[k][0];
            d32 = {b2b_vals[k], 24'h00_0000};
            step();
            chk($sformatf("b2b%0d_q8", k), 64'(q8), 64'(b2b_vals[k]));
            chk($sformatf("b2b%0d_q1", k), 64'(q1), (k == 0) ? 64'h1 : 64'h0);
            chk($sformatf("b2b%0d_q32", k), 64'(q32), 64'({b2b_vals[k], 24'h00_0000}));
`ifdef N_BIT_REGISTER_PARITY_EN
            chk($sformatf("b2b%0d_p8", k), 64'(p8), 64'(b2b_parity[k]));
`endif
        end

        // Reset and write on the same edge: reset wins, then the write lands.
        reset = 1'b1;
        d8    = 8'h55;
        d1    = 1'b1;
        d32   = 32'h1234_5678;
        step();
        chk("rst_vs_wr_q8", 64'(q8), 64'h00);
        chk("rst_vs_wr_q1", 64'(q1), 64'h0);
        chk("rst_vs_wr_q32", 64'(q32), 64'h0);
        reset = 1'b0;
        step();
        chk("post_rst_wr_q8", 64'(q8), 64'h55);
        chk("post_rst_wr_q1", 64'(q1), 64'h1);
        chk("post_rst_wr_q32", 64'(q32), 64'h1234_5678);
`ifdef N_BIT_REGISTER_PARITY_EN
        chk("post_rst_wr_p8", 64'(p8), 64'h0);
        chk("post_rst_wr_p32", 64'(p32), 64'h1);
`endif

        // Single-bit width: clear and hold zero.
        d1 = 1'b0;
        step();
        chk("w1_clear_q1", 64'(q1), 64'h0);
        write_enable = 1'b0;
        d1           = 1'b1;
        step();
        chk("w1_hold_q1", 64'(q1), 64'h0);
        chk("w1_hold_q8", 64'(q8), 64'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
